// File: rtl/jtroadf_prog_remap_if.sv
// SDRAM programming port bundle: request address/data/strobe
// and the ready handshake that returns from the SDRAM side.
interface jtroadf_prog_remap_if;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic        prog_we;
    logic        prog_rdy;

    modport master (
        output prog_addr, prog_data, prog_we,
        input  prog_rdy
    );

    modport slave (
        input  prog_addr, prog_data, prog_we,
        output prog_rdy
    );
endinterface

// File: rtl/jtroadf_prog_remap.sv
// Road Fighter / Hyper Sports download conditioner: region swizzle,
// SDRAM write FIFO with request/ready drain, PROM strobe path.
module jtroadf_prog_remap #(
    parameter logic [21:0] SCR_START  = 22'h0,
    parameter logic [21:0] OBJ_START  = 22'h0,
    parameter logic [21:0] PCM_START  = 22'h0,
    parameter logic [24:0] PROM_START = 25'h0,
    parameter int          DEPTH      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        ioctl_wr,
    jtroadf_prog_remap_if.master prog,
    output logic [10:0] prom_addr,
    output logic [7:0]  prom_data,
    output logic        prom_we,
    output logic        is_hyper,
    output logic        ovf,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [21:0] addr;
        logic [7:0]  data;
    } ent_t;

    typedef enum logic [1:0] {IDLE, WR, GAP} state_t;

    logic        wr_en;
    logic        in_prom;
    logic        in_scr;
    logic        in_obj;
    logic [21:0] a;
    logic [21:0] sw;
    logic [10:0] prom_off;

    assign wr_en    = ioctl_wr & downloading;
    assign in_prom  = ioctl_addr >= PROM_START;
    assign in_scr   = ioctl_addr >= {3'b0, SCR_START} &&
                      ioctl_addr <  {3'b0, OBJ_START};
    assign in_obj   = ioctl_addr >= {3'b0, OBJ_START} &&
                      ioctl_addr <  {3'b0, PCM_START};
    assign a        = ioctl_addr[21:0];
    assign prom_off = ioctl_addr[10:0] - PROM_START[10:0];

    // Bit-plane swizzle applied to the low address bits per region
    always_comb begin
        sw = a;
        unique case (1'b1)
            in_scr:  sw[3:0] = {a[2:0], ~a[3]};
            in_obj:  sw[4:0] = {a[2:0], ~a[4], ~a[3]};
            default: ;
        endcase
    end

    logic s1_vld;
    ent_t s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld    <= 1'b0;
            s1        <= '0;
            prom_we   <= 1'b0;
            prom_addr <= '0;
            prom_data <= '0;
        end else begin
            s1_vld  <= wr_en & ~in_prom;
            prom_we <= wr_en & in_prom;
            if (wr_en & ~in_prom)
                s1 <= '{addr: sw, data: ioctl_dout};
            if (wr_en & in_prom) begin
                prom_addr <= prom_off;
                prom_data <= ioctl_dout;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            is_hyper <= 1'b0;
        else if (prom_we && prom_addr == 11'd1)
            is_hyper <= &prom_data;
    end

    ent_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          drop;
    state_t        state;
    state_t        nxt;
    logic          load;
    ent_t          head;

    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    assign pop   = (state == WR) & prog.prog_rdy;
    assign push  = s1_vld & (~full | pop);
    assign drop  = s1_vld & full & ~pop;
    // An empty FIFO being written this cycle forwards the new entry
    assign head  = empty ? s1 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= s1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt  = state;
        load = 1'b0;
        unique case (state)
            IDLE: if (!empty || push) begin
                nxt  = WR;
                load = 1'b1;
            end
            WR:      if (prog.prog_rdy) nxt = GAP;
            GAP:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog.prog_addr <= '0;
            prog.prog_data <= '0;
        end else if (load) begin
            prog.prog_addr <= head.addr;
            prog.prog_data <= head.data;
        end
    end

    assign prog.prog_we = state == WR;

    logic dl_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_q <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            dl_q <= downloading;
            if (drop)
                ovf <= 1'b1;
            else if (downloading & ~dl_q)
                ovf <= 1'b0;
        end
    end

    assign busy = rst_n & (downloading | ~empty | state != IDLE);

endmodule

// File: tb/tb_jtroadf_prog_remap.sv
// Directed bench for jtroadf_prog_remap: swizzle, PROM path,
// backpressure/overflow, full push+pop and mid-write reset.
module tb_jtroadf_prog_remap;

    localparam logic [21:0] SCR = 22'h10000;
    localparam logic [21:0] OBJ = 22'h20000;
    localparam logic [21:0] PCM = 22'h30000;
    localparam logic [24:0] PRM = 25'h100000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        downloading = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        ioctl_wr = 1'b0;
    logic [10:0] prom_addr;
    logic [7:0]  prom_data;
    logic        prom_we;
    logic        is_hyper;
    logic        ovf;
    logic        busy;

    int total = 0;
    int bad = 0;

    jtroadf_prog_remap_if pif ();

    jtroadf_prog_remap #(
        .SCR_START(SCR), .OBJ_START(OBJ), .PCM_START(PCM),
        .PROM_START(PRM), .DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wr(ioctl_wr), .prog(pif),
        .prom_addr(prom_addr), .prom_data(prom_data),
        .prom_we(prom_we), .is_hyper(is_hyper),
        .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Back-to-back bytes; returns at the cycle after the last byte
    task automatic stream(input logic [24:0] base,
                          input logic [7:0] d0, input int n);
        for (int i = 0; i < n; i++) begin
            ioctl_addr = base + 25'(i);
            ioctl_dout = d0 + 8'(i);
            ioctl_wr   = 1'b1;
            step();
        end
        ioctl_wr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pif.prog_rdy = 1'b0;
        step();
        total++; if (pif.prog_we !== 1'b0) begin bad++; $display("FAIL rst_prog_we got=%b want=0", pif.prog_we); end
        total++; if (pif.prog_addr !== 22'h0) begin bad++; $display("FAIL rst_prog_addr got=%h want=0", pif.prog_addr); end
        total++; if (prom_we !== 1'b0) begin bad++; $display("FAIL rst_prom_we got=%b want=0", prom_we); end
        total++; if ({ovf, busy, is_hyper} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b want=000", {ovf, busy, is_hyper}); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_scroll();
        downloading = 1'b1;
        stream({3'b0, 22'h10005}, 8'hA5, 1);
        total++; if (pif.prog_we !== 1'b0) begin bad++; $display("FAIL scr_we_n1 got=%b want=0", pif.prog_we); end
        step();
        total++; if (pif.prog_we !== 1'b1) begin bad++; $display("FAIL scr_we_n2 got=%b want=1", pif.prog_we); end
        total++; if (pif.prog_addr !== 22'h1000B) begin bad++; $display("FAIL scr_addr got=%h want=1000b", pif.prog_addr); end
        total++; if (pif.prog_data !== 8'hA5) begin bad++; $display("FAIL scr_data got=%h want=a5", pif.prog_data); end
        pif.prog_rdy = 1'b1;
        step();
        pif.prog_rdy = 1'b0;
        total++; if (pif.prog_we !== 1'b0) begin bad++; $display("FAIL scr_gap got=%b want=0", pif.prog_we); end
        step();
        step();
    endtask

    task automatic test_object();
        stream({3'b0, 22'h20008}, 8'h3C, 1);
        step();
        total++; if (pif.prog_addr !== 22'h20002 || pif.prog_we !== 1'b1) begin bad++; $display("FAIL obj_addr8 got=%h/%b want=20002/1", pif.prog_addr, pif.prog_we); end
        total++; if (pif.prog_data !== 8'h3C) begin bad++; $display("FAIL obj_data got=%h want=3c", pif.prog_data); end
        pif.prog_rdy = 1'b1; step(); pif.prog_rdy = 1'b0;
        step(); step();
        stream({3'b0, 22'h20010}, 8'h55, 1);
        step();
        total++; if (pif.prog_addr !== 22'h20001 || pif.prog_we !== 1'b1) begin bad++; $display("FAIL obj_addr10 got=%h/%b want=20001/1", pif.prog_addr, pif.prog_we); end
        pif.prog_rdy = 1'b1; step(); pif.prog_rdy = 1'b0;
        step(); step();
    endtask

    task automatic test_prom();
        stream(PRM + 25'd1, 8'hFF, 1);
        total++; if (prom_we !== 1'b1 || prom_addr !== 11'h001) begin bad++; $display("FAIL prom_strobe got=%b/%h want=1/001", prom_we, prom_addr); end
        total++; if (prom_data !== 8'hFF) begin bad++; $display("FAIL prom_data got=%h want=ff", prom_data); end
        step();
        total++; if (prom_we !== 1'b0) begin bad++; $display("FAIL prom_one_cycle got=%b want=0", prom_we); end
        total++; if (is_hyper !== 1'b1) begin bad++; $display("FAIL hyper_set got=%b want=1", is_hyper); end
        for (int c = 0; c < 3; c++) begin
            total++; if (pif.prog_we !== 1'b0) begin bad++; $display("FAIL prom_no_prog got=%b want=0", pif.prog_we); end
            step();
        end
        stream(PRM + 25'd1, 8'h7F, 1);
        step();
        total++; if (is_hyper !== 1'b0) begin bad++; $display("FAIL hyper_clr got=%b want=0", is_hyper); end
    endtask

    task automatic test_overflow();
        int nreq;
        int last;
        int fall;
        logic prev;
        pif.prog_rdy = 1'b0;
        stream({3'b0, PCM}, 8'h10, 6);
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", ovf); end
        step();
        total++; if (pif.prog_addr !== PCM || pif.prog_we !== 1'b1) begin bad++; $display("FAIL ovf_head got=%h/%b want=%h/1", pif.prog_addr, pif.prog_we, PCM); end
        downloading = 1'b0;
        pif.prog_rdy = 1'b1;
        nreq = 0; last = -1; fall = -1; prev = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (pif.prog_we) begin
                total++; if (prev) begin bad++; $display("FAIL ovf_gap got=back-to-back want=low cycle at %0d", c); end
                total++; if (pif.prog_addr !== PCM + 22'(nreq) || pif.prog_data !== 8'h10 + 8'(nreq)) begin bad++; $display("FAIL ovf_order got=%h/%h want=%h/%h", pif.prog_addr, pif.prog_data, PCM + 22'(nreq), 8'h10 + 8'(nreq)); end
                nreq++;
                last = c;
            end
            if (!busy && fall < 0) fall = c;
            prev = pif.prog_we;
            step();
        end
        pif.prog_rdy = 1'b0;
        total++; if (nreq != 4) begin bad++; $display("FAIL ovf_count got=%0d want=4", nreq); end
        total++; if (fall != last + 2) begin bad++; $display("FAIL busy_fall got=%0d want=%0d", fall, last + 2); end
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", ovf); end
        downloading = 1'b1;
        step();
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", ovf); end
    endtask

    task automatic test_back_to_back();
        int nreq;
        pif.prog_rdy = 1'b0;
        stream({3'b0, PCM + 22'h10}, 8'h20, 4);
        step();
        total++; if (pif.prog_addr !== PCM + 22'h10 || pif.prog_we !== 1'b1) begin bad++; $display("FAIL pp_head got=%h/%b want=%h/1", pif.prog_addr, pif.prog_we, PCM + 22'h10); end
        stream({3'b0, PCM + 22'h14}, 8'h24, 1);
        pif.prog_rdy = 1'b1;
        step();
        pif.prog_rdy = 1'b0;
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL pp_ovf got=%b want=0", ovf); end
        downloading = 1'b0;
        pif.prog_rdy = 1'b1;
        nreq = 0;
        for (int c = 0; c < 30; c++) begin
            if (pif.prog_we) begin
                total++; if (pif.prog_addr !== PCM + 22'h11 + 22'(nreq) || pif.prog_data !== 8'h21 + 8'(nreq)) begin bad++; $display("FAIL pp_order got=%h/%h want=%h/%h", pif.prog_addr, pif.prog_data, PCM + 22'h11 + 22'(nreq), 8'h21 + 8'(nreq)); end
                nreq++;
            end
            step();
        end
        pif.prog_rdy = 1'b0;
        total++; if (nreq != 4) begin bad++; $display("FAIL pp_count got=%0d want=4", nreq); end
        total++; if (busy !== 1'b0 || ovf !== 1'b0) begin bad++; $display("FAIL pp_idle got=%b/%b want=0/0", busy, ovf); end
    endtask

    task automatic test_reset_mid();
        downloading = 1'b1;
        pif.prog_rdy = 1'b0;
        step();
        stream({3'b0, PCM + 22'h20}, 8'h30, 3);
        ioctl_addr = PRM + 25'd1; ioctl_dout = 8'hFF; ioctl_wr = 1'b1;
        step();
        ioctl_addr = PRM + 25'd2; ioctl_dout = 8'h00;
        step();
        ioctl_wr = 1'b0;
        total++; if ({prom_we, is_hyper, pif.prog_we, busy} !== 4'b1111) begin bad++; $display("FAIL rm_pre got=%b want=1111", {prom_we, is_hyper, pif.prog_we, busy}); end
        downloading = 1'b0;
        rst_n = 1'b0;
        #1;
        total++; if ({pif.prog_we, prom_we, ovf, busy, is_hyper} !== 5'b0) begin bad++; $display("FAIL rm_async got=%b want=00000", {pif.prog_we, prom_we, ovf, busy, is_hyper}); end
        step(); step();
        rst_n = 1'b1;
        downloading = 1'b1;
        for (int c = 0; c < 8; c++) begin
            total++; if (pif.prog_we !== 1'b0) begin bad++; $display("FAIL rm_quiet got=%b want=0 at %0d", pif.prog_we, c); end
            step();
        end
        stream({3'b0, PCM + 22'h30}, 8'h40, 1);
        step();
        total++; if (pif.prog_we !== 1'b1 || pif.prog_addr !== PCM + 22'h30) begin bad++; $display("FAIL rm_new got=%b/%h want=1/%h", pif.prog_we, pif.prog_addr, PCM + 22'h30); end
        pif.prog_rdy = 1'b1; step(); pif.prog_rdy = 1'b0;
        step(); step();
    endtask

    initial begin
        test_reset();
        test_scroll();
        test_object();
        test_prom();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
